// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding instruction-memory read, registered IF/ID slot
// with a one-entry hold buffer, decode stall and branch/jump flush handling.
module instruction_fetch #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc,
  output logic         pc_advance,
  output logic         imem_req_valid,
  output logic [N-1:0] imem_req_addr,
  input  logic         imem_req_ready,
  input  logic         imem_resp_valid,
  input  logic [N-1:0] imem_resp_data,
  input  logic         id_ready,
  input  logic         flush,
  output logic         if_valid,
  output logic [N-1:0] if_instr,
  output logic [N-1:0] if_pc,
  output logic [N-1:0] if_pc_plus4,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t       r_state;
  logic [N-1:0] r_req_pc;
  logic         r_hold_valid;
  logic [N-1:0] r_hold_instr;
  logic [N-1:0] r_hold_pc;
  logic         r_if_valid;
  logic [N-1:0] r_if_instr;
  logic [N-1:0] r_if_pc;

  logic w_req_fire;
  logic w_slot_free;

  // Handshakes: a request transfers in a cycle where imem_req_valid and
  // imem_req_ready are both high; responses have no back-pressure and are
  // taken the cycle imem_resp_valid is high; decode takes if_* when
  // if_valid and id_ready are both high.
  assign imem_req_valid = reset && (r_state == S_REQ) && !flush;
  assign imem_req_addr  = pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign pc_advance     = w_req_fire;
  assign w_slot_free    = !r_if_valid || id_ready;

  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc + N'(4);
  assign dbg_state   = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_REQ;
      r_req_pc     <= '0;
      r_hold_valid <= 1'b0;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= '0;
      r_if_pc      <= '0;
    end else if (flush) begin
      r_if_valid   <= 1'b0;
      r_hold_valid <= 1'b0;
      case (r_state)
        S_REQ:     r_state <= S_REQ;
        S_WAIT:    r_state <= imem_resp_valid ? S_REQ : S_DISCARD;
        S_HOLD:    r_state <= S_REQ;
        S_DISCARD: r_state <= S_DISCARD;
        default:   r_state <= S_REQ;
      endcase
    end else begin
      if (r_if_valid && id_ready) r_if_valid <= 1'b0;
      case (r_state)
        S_REQ: begin
          if (w_req_fire) begin
            r_req_pc <= pc;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (w_slot_free) begin
              r_if_valid <= 1'b1;
              r_if_instr <= imem_resp_data;
              r_if_pc    <= r_req_pc;
              r_state    <= S_REQ;
            end else begin
              r_hold_valid <= 1'b1;
              r_hold_instr <= imem_resp_data;
              r_hold_pc    <= r_req_pc;
              r_state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Only entered with the slot occupied, so id_ready drains it and
          // the held word refills it in the same edge.
          if (id_ready && r_hold_valid) begin
            r_if_valid   <= 1'b1;
            r_if_instr   <= r_hold_instr;
            r_if_pc      <= r_hold_pc;
            r_hold_valid <= 1'b0;
            r_state      <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (imem_resp_valid) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cycle table for the corner cases, then
// random traffic checked against an in-order fetch scoreboard.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_advance;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_ready;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch #(.N(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_advance      (pc_advance),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_ready        (id_ready),
    .flush           (flush),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // directed vectors: inputs applied after negedge, all outputs checked 1ns later
  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        idr;
    logic        fl;
    logic        e_rv;
    logic        e_adv;
    logic        e_iv;
    logic [31:0] e_ii;
    logic [31:0] e_ip;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic rst, input logic [31:0] p, input logic rdy, input logic rv,
                     input logic [31:0] rd, input logic idr, input logic fl,
                     input logic e_rv, input logic e_adv, input logic e_iv,
                     input logic [31:0] e_ii, input logic [31:0] e_ip, input logic [1:0] e_st);
    vec_t v;
    v.rst = rst; v.pc = p; v.rdy = rdy; v.rv = rv; v.rd = rd; v.idr = idr; v.fl = fl;
    v.e_rv = e_rv; v.e_adv = e_adv; v.e_iv = e_iv; v.e_ii = e_ii; v.e_ip = e_ip; v.e_st = e_st;
    vec_q.push_back(v);
  endtask

  localparam logic [31:0] D   = 32'h20080005;
  localparam logic [31:0] D2  = 32'h8C090000;
  localparam logic [31:0] D3  = 32'h01095020;
  localparam logic [31:0] D4  = 32'hAC0A0004;
  localparam logic [31:0] D5  = 32'h12345678;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  // behavioural reference for random traffic
  logic [31:0] exp_q[$];
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_due;
  int          cyc;
  int          delivered;
  logic [31:0] next_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic rand_cycle(input bit drain);
    logic        outstanding;
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    pc = next_pc;
    outstanding = mem_pend;
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_pend && cyc >= mem_due) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mem_addr);
      mem_pend = 1'b0;
    end
    if (drain) begin
      imem_req_ready = 1'b0;
      id_ready       = 1'b1;
      flush          = 1'b0;
    end else begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      // a flush coinciding with the response that DISCARD waits for would strand it
      flush          = !imem_resp_valid && ($urandom_range(0, 19) == 0);
    end
    #1;
    chk("rnd_addr", imem_req_addr, pc);
    chk("rnd_adv", {31'd0, pc_advance}, {31'd0, imem_req_valid & imem_req_ready});
    if (outstanding) chk("rnd_single_outstanding", {31'd0, imem_req_valid}, 32'd0);
    if (flush) chk("rnd_no_req_on_flush", {31'd0, imem_req_valid}, 32'd0);
    if (if_valid && id_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("rnd_unexpected_delivery", if_pc, 32'hFFFF_FFFF ^ if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("rnd_if_pc", if_pc, e);
        chk("rnd_if_instr", if_instr, mem_word(e));
        chk("rnd_if_pc_plus4", if_pc_plus4, e + 32'd4);
        delivered++;
      end
    end
    if (pc_advance) begin
      mem_pend = 1'b1;
      mem_addr = pc;
      mem_due  = cyc + $urandom_range(1, 3);
      exp_q.push_back(pc);
    end
    if (flush) begin
      exp_q.delete();
      next_pc = {$urandom_range(32'h0010_0000, 32'h3FFF_FFFF), 2'b00};
    end else if (pc_advance) begin
      next_pc = pc + 32'd4;
    end else begin
      next_pc = pc;
    end
  endtask

  initial begin
    vec_t v;
    int   k;
    reset = 1'b0; pc = 32'h0040_0000; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = '0; id_ready = 1'b0; flush = 1'b0;

    // reset release, 1-cycle memory
    add(0, 32'h00400000, 1, 0, 0,   1, 0,  0, 0, 0, 0,  0,            0);
    add(1, 32'h00400000, 1, 0, 0,   1, 0,  1, 1, 0, 0,  0,            0);
    add(1, 32'h00400004, 1, 1, D,   1, 0,  0, 0, 0, 0,  0,            1);
    add(1, 32'h00400004, 0, 0, 0,   0, 0,  1, 0, 1, D,  32'h00400000, 0);
    // ready low for 2 cycles, 3-cycle latency
    add(1, 32'h00400004, 0, 0, 0,   0, 0,  1, 0, 1, D,  32'h00400000, 0);
    add(1, 32'h00400004, 1, 0, 0,   1, 0,  1, 1, 1, D,  32'h00400000, 0);
    add(1, 32'h00400008, 1, 0, 0,   1, 0,  0, 0, 0, D,  32'h00400000, 1);
    add(1, 32'h00400008, 1, 0, 0,   1, 0,  0, 0, 0, D,  32'h00400000, 1);
    add(1, 32'h00400008, 1, 1, D2,  1, 0,  0, 0, 0, D,  32'h00400000, 1);
    add(1, 32'h00400008, 1, 0, 0,   0, 0,  1, 1, 1, D2, 32'h00400004, 0);
    // response while decode stalled -> HOLD
    add(1, 32'h0040000C, 1, 1, D3,  0, 0,  0, 0, 1, D2, 32'h00400004, 1);
    add(1, 32'h0040000C, 1, 0, 0,   0, 0,  0, 0, 1, D2, 32'h00400004, 2);
    add(1, 32'h0040000C, 1, 0, 0,   1, 0,  0, 0, 1, D2, 32'h00400004, 2);
    add(1, 32'h0040000C, 1, 0, 0,   0, 0,  1, 1, 1, D3, 32'h00400008, 0);
    // flush in WAIT, late response discarded
    add(1, 32'h00400010, 1, 0, 0,   0, 1,  0, 0, 1, D3, 32'h00400008, 1);
    add(1, 32'h00400100, 1, 0, 0,   1, 0,  0, 0, 0, D3, 32'h00400008, 3);
    add(1, 32'h00400100, 1, 1, BAD, 1, 0,  0, 0, 0, D3, 32'h00400008, 3);
    add(1, 32'h00400100, 1, 0, 0,   1, 0,  1, 1, 0, D3, 32'h00400008, 0);
    add(1, 32'h00400104, 1, 1, D4,  1, 0,  0, 0, 0, D3, 32'h00400008, 1);
    add(1, 32'h00400104, 1, 0, 0,   0, 0,  1, 1, 1, D4, 32'h00400100, 0);
    // flush coincident with response, decode stalled
    add(1, 32'h00400108, 1, 1, D5,  0, 1,  0, 0, 1, D4, 32'h00400100, 1);
    add(1, 32'h00400200, 0, 0, 0,   0, 0,  1, 0, 0, D4, 32'h00400100, 0);
    // reset during WAIT, late response ignored
    add(1, 32'h00400200, 1, 0, 0,   1, 0,  1, 1, 0, D4, 32'h00400100, 0);
    add(0, 32'h00400204, 1, 0, 0,   1, 0,  0, 0, 0, 0,  0,            0);
    add(1, 32'h00400000, 0, 1, BAD, 1, 0,  1, 0, 0, 0,  0,            0);
    add(1, 32'h00400000, 1, 0, 0,   1, 0,  1, 1, 0, 0,  0,            0);
    add(1, 32'h00400004, 1, 1, D,   1, 0,  0, 0, 0, 0,  0,            1);
    add(1, 32'h00400004, 0, 0, 0,   0, 0,  1, 0, 1, D,  32'h00400000, 0);
    // if_pc_plus4 wraps
    add(1, 32'hFFFFFFFC, 1, 0, 0,   1, 0,  1, 1, 1, D,  32'h00400000, 0);
    add(1, 32'h00000000, 1, 1, D2,  1, 0,  0, 0, 0, D,  32'h00400000, 1);
    add(1, 32'h00000000, 0, 0, 0,   0, 0,  1, 0, 1, D2, 32'hFFFFFFFC, 0);

    for (int i = 0; i < vec_q.size(); i++) begin
      v = vec_q[i];
      @(negedge clk);
      reset = v.rst; pc = v.pc; imem_req_ready = v.rdy; imem_resp_valid = v.rv;
      imem_resp_data = v.rd; id_ready = v.idr; flush = v.fl;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, v.e_rv});
      chk($sformatf("v%0d_pc_advance", i), {31'd0, pc_advance}, {31'd0, v.e_adv});
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, v.pc);
      chk($sformatf("v%0d_if_valid", i), {31'd0, if_valid}, {31'd0, v.e_iv});
      chk($sformatf("v%0d_if_instr", i), if_instr, v.e_ii);
      chk($sformatf("v%0d_if_pc", i), if_pc, v.e_ip);
      chk($sformatf("v%0d_if_pc_plus4", i), if_pc_plus4, v.e_ip + 32'd4);
      chk($sformatf("v%0d_state", i), {30'd0, dbg_state}, {30'd0, v.e_st});
    end

    // random traffic from a clean reset
    @(negedge clk);
    reset = 1'b0; imem_resp_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    mem_pend = 1'b0; mem_addr = '0; mem_due = 0; cyc = 0; delivered = 0;
    next_pc = 32'h0040_0000;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
    k = 0;
    while ((exp_q.size() != 0 || mem_pend) && k < 40) begin
      rand_cycle(1'b1);
      k++;
    end
    chk("rnd_drained", exp_q.size(), 32'd0);
    chk("rnd_progress", {31'd0, delivered > 300}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
